// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the sequence-detector scheduler.
package seq_det_pkg;

  localparam int unsigned DefWordW = 8;
  localparam int unsigned DefTotW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/seq_sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; synchronous clear.
module seq_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_det_scheduler.sv
// Serialises words MSB-first into a sequence detector and collects per-word hit
// counts, hit-position maps and a saturating running total.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int unsigned WORD_W = DefWordW,
  parameter int unsigned TOT_W  = DefTotW,
  localparam int unsigned CNT_W = $clog2(WORD_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clear_between,
  input  logic              abort,
  output logic              det_x,
  output logic              det_rst,
  input  logic              det_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_map,
  output logic [TOT_W-1:0]  total_hits
);

  localparam int unsigned IdxW = $clog2(WORD_W);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d, cnt_q, cnt_d;
  logic [WORD_W-1:0] acc_map_q, acc_map_d, map_q, map_d;
  logic              in_ready_c, det_rst_c, hit;

  // Working accumulators are separate from the published result so that
  // out_count/out_map stay put while the next word is being shifted.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    idx_d      = idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_map_d  = acc_map_q;
    cnt_d      = cnt_q;
    map_d      = map_q;
    in_ready_c = 1'b0;
    det_rst_c  = 1'b0;
    det_x      = 1'b0;
    out_valid  = 1'b0;
    hit        = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          data_d    = in_data;
          idx_d     = IdxW'(WORD_W - 1);
          acc_cnt_d = '0;
          acc_map_d = '0;
          state_d   = clear_between ? StClear : StShift;
        end
      end
      StClear: begin
        det_rst_c = 1'b1;
        state_d   = abort ? StIdle : StShift;
      end
      StShift: begin
        det_x = data_q[idx_q];
        if (abort) begin
          det_rst_c = 1'b1;
          state_d   = StIdle;
        end else begin
          hit = det_y;
          if (det_y) begin
            acc_cnt_d        = acc_cnt_q + CNT_W'(1);
            acc_map_d[idx_q] = 1'b1;
          end
          if (idx_q == '0) begin
            state_d = StDone;
            cnt_d   = acc_cnt_d;
            map_d   = acc_map_d;
          end else begin
            idx_d = idx_q - IdxW'(1);
          end
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      data_q    <= '0;
      idx_q     <= '0;
      acc_cnt_q <= '0;
      acc_map_q <= '0;
      cnt_q     <= '0;
      map_q     <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      acc_cnt_q <= acc_cnt_d;
      acc_map_q <= acc_map_d;
      cnt_q     <= cnt_d;
      map_q     <= map_d;
    end
  end

  assign in_ready  = in_ready_c & ~rst;
  assign det_rst   = det_rst_c | rst;
  assign out_count = cnt_q;
  assign out_map   = map_q;

  seq_sat_counter #(
    .Width(TOT_W)
  ) u_total (
    .clk_i  (clk),
    .rst_i  (rst),
    .inc_i  (hit),
    .clr_i  (1'b0),
    .count_o(total_hits)
  );

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Sequencing controller for the team's serial sequence-detector FSM (single-bit input x, single-bit detect output y).
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first onto the detector's x input, one bit per clock.
- Samples the detector's y output on every bit and returns a per-word hit count and hit-position map.
- Optionally resets the detector between words, and keeps a running saturating total of hits.

Parameters:
WORD_W, 8, bits per input word (>=2).
TOT_W, 16, width of running total-hit counter.
CNT_W, localparam = $clog2(WORD_W+1), width of per-word hit count.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input word valid.
in_data  in  WORD_W  word to serialise, MSB shifted first.
in_ready  out  1  block can accept a word.
clear_between  in  1  1 = reset detector before each word; sampled at word accept.
abort  in  1  synchronous abort of word in progress.
det_x  out  1  serial bit to detector x.
det_rst  out  1  reset to detector (active-high).
det_y  in  1  detector output y; Mealy, valid in same cycle as det_x.
out_valid  out  1  result valid.
out_ready  in  1  result consumed.
out_count  out  CNT_W  hits in last word.
out_map  out  WORD_W  bit k = 1 if det_y was 1 while in_data[k] was on det_x.
total_hits  out  TOT_W  saturating hits since reset.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst high; out_valid=0, out_count=0, out_map=0, total_hits=0, det_x=0; det_rst=1 (combinationally follows rst).
- States: IDLE, CLEAR, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data, latch clear_between, clear hit count/map, bit index=WORD_W-1.
  - Next state is CLEAR if clear_between=1, else SHIFT.
- CLEAR: exactly 1 cycle. det_rst=1, det_x=0, y ignored. Next state SHIFT.
- SHIFT: WORD_W cycles.
  - det_x = latched bit[idx].
  - Same cycle: if det_y=1, set map[idx], count+1, total_hits+1 (saturating at all-ones).
  - idx decrements; after idx=0 go to DONE.
- DONE:
  - out_valid=1 with out_count/out_map stable until out_valid&out_ready; then return to IDLE.
  - in_ready=0 in DONE, so no back-to-back overlap.
- Latency, accept to out_valid: WORD_W+1 cycles (clear_between=0) or WORD_W+2 cycles (clear_between=1).
- det_x=0 and det_rst=0 outside SHIFT and CLEAR, except det_rst=1 during rst.
- Detector clock advances every cycle. The block's contract is that the detector only sees meaningful x during SHIFT. In IDLE and DONE it receives x=0, so with clear_between=0 detector state after a word may evolve on idle zeros. Bench must treat carry-over as x-stream including those zeros.
- abort=1 in CLEAR or SHIFT:
  - Next state IDLE, no out_valid.
  - det_rst=1 for that one cycle.
  - Hits already counted in total_hits remain.
  - In IDLE/DONE, abort is ignored.
- Simultaneous abort and last SHIFT bit: abort wins; that bit's det_y is not counted.
- out_count never exceeds WORD_W, so no overflow. total_hits holds at 2^TOT_W-1.
- out_count/out_map retain the last result after handshake until the next word completes.

Decomposition:
- Shared package seq_det_pkg: state enum (IDLE, CLEAR, SHIFT, DONE), default WORD_W/TOT_W.
- One natural sub-module: seq_sat_counter (parameterised width, inc, clear, saturate) for total_hits.
- Shift/index logic stays inline.

Test Plan:
- Reset: hold rst=1 for 100 ns -> all outputs at reset values, det_rst=1. Deassert -> in_ready=1, det_rst=0.
- Detector model for "1011" overlapping, in_data=8'b1011_0110, clear_between=1 -> one det_rst pulse, det_x stream 1,0,1,1,0,1,1,0; out_count=2, out_map=8'b0001_0010, out_valid 10 cycles after accept, total_hits=2.
- Backpressure: out_ready=0 for 5 cycles -> out_valid held, outputs stable, in_ready=0 throughout; on release, one handshake then in_ready=1.
- Abort: abort at 3rd SHIFT cycle -> IDLE next cycle, det_rst=1 for one cycle, no out_valid, total_hits unchanged except hits seen before abort.
- Saturation with TOT_W=2, 0xFF words, and a detector model of y=x -> total_hits stops at 3, out_count=8 per word.
- Async rst asserted mid-SHIFT -> immediate return to reset values without waiting for clk. After release, the next word is processed normally.
